// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline definitions: widths, ALU codes and EX-stage bundles.
package rv32_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned RADDR_W   = 5;
  localparam int unsigned ALUCNTL_W = 4;
  localparam int unsigned FUNCT_W   = 3;

  localparam logic [ALUCNTL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALUCNTL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALUCNTL_W-1:0] ALU_XOR = 4'b0010;
  localparam logic [ALUCNTL_W-1:0] ALU_SLL = 4'b0011;
  localparam logic [ALUCNTL_W-1:0] ALU_SRL = 4'b0100;
  localparam logic [ALUCNTL_W-1:0] ALU_SRA = 4'b0101;
  localparam logic [ALUCNTL_W-1:0] ALU_ADD = 4'b0110;
  localparam logic [ALUCNTL_W-1:0] ALU_SUB = 4'b0111;

  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 3'b010;

  // Control fields held in the ID/EX register.
  typedef struct packed {
    logic                 valid;
    logic [RADDR_W-1:0]   rd;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 alu_src;
    logic                 alu_pc;
    logic [ALUCNTL_W-1:0] alucntl;
    logic [FUNCT_W-1:0]   funct;
  } ex_ctrl_t;

  // Data fields held in the ID/EX register.
  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [RADDR_W-1:0] rs1_addr;
    logic [RADDR_W-1:0] rs2_addr;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    logic [XLEN-1:0]    imm;
  } ex_data_t;

  // A bubble is an ADD of nothing into x0 that never commits.
  localparam ex_ctrl_t BUBBLE_CTRL = '{
    valid:     1'b0,
    rd:        '0,
    reg_write: 1'b0,
    mem_read:  1'b0,
    mem_write: 1'b0,
    alu_src:   1'b0,
    alu_pc:    1'b0,
    alucntl:   ALU_ADD,
    funct:     '0
  };

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: ID fields, pipeline control, forwarding sources, EX outputs.
interface id_ex_stage_if;
  import rv32_pkg::*;

  logic                 id_valid;
  logic [XLEN-1:0]      id_pc;
  logic [RADDR_W-1:0]   id_rs1_addr;
  logic [RADDR_W-1:0]   id_rs2_addr;
  logic [RADDR_W-1:0]   id_rd_addr;
  logic                 id_uses_rs1;
  logic                 id_uses_rs2;
  logic [XLEN-1:0]      id_rs1_data;
  logic [XLEN-1:0]      id_rs2_data;
  logic [XLEN-1:0]      id_imm;
  logic                 id_alu_src;
  logic                 id_alu_pc;
  logic [ALUCNTL_W-1:0] id_alucntl;
  logic [FUNCT_W-1:0]   id_funct;
  logic                 id_reg_write;
  logic                 id_mem_read;
  logic                 id_mem_write;
  logic                 pipe_hold;
  logic                 ex_flush;
  logic [RADDR_W-1:0]   exmem_rd;
  logic                 exmem_reg_write;
  logic [XLEN-1:0]      exmem_result;
  logic [RADDR_W-1:0]   memwb_rd;
  logic                 memwb_reg_write;
  logic [XLEN-1:0]      memwb_result;

  logic                 id_stall;
  logic                 ex_valid;
  logic [XLEN-1:0]      ex_op1;
  logic [XLEN-1:0]      ex_op2;
  logic [ALUCNTL_W-1:0] ex_alucntl;
  logic [FUNCT_W-1:0]   ex_funct;
  logic [XLEN-1:0]      ex_store_data;
  logic [XLEN-1:0]      ex_pc;
  logic [RADDR_W-1:0]   ex_rd;
  logic                 ex_reg_write;
  logic                 ex_mem_read;
  logic                 ex_mem_write;

  modport master (
    output id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rd_addr,
           id_uses_rs1, id_uses_rs2, id_rs1_data, id_rs2_data, id_imm,
           id_alu_src, id_alu_pc, id_alucntl, id_funct,
           id_reg_write, id_mem_read, id_mem_write,
           pipe_hold, ex_flush,
           exmem_rd, exmem_reg_write, exmem_result,
           memwb_rd, memwb_reg_write, memwb_result,
    input  id_stall, ex_valid, ex_op1, ex_op2, ex_alucntl, ex_funct,
           ex_store_data, ex_pc, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rd_addr,
           id_uses_rs1, id_uses_rs2, id_rs1_data, id_rs2_data, id_imm,
           id_alu_src, id_alu_pc, id_alucntl, id_funct,
           id_reg_write, id_mem_read, id_mem_write,
           pipe_hold, ex_flush,
           exmem_rd, exmem_reg_write, exmem_result,
           memwb_rd, memwb_reg_write, memwb_result,
    output id_stall, ex_valid, ex_op1, ex_op2, ex_alucntl, ex_funct,
           ex_store_data, ex_pc, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write
  );

endinterface

// File: rtl/id_ex_stage_fwd_unit.sv
// Per-operand RAW forwarding mux; EX/MEM beats MEM/WB and x0 is never forwarded.
module fwd_unit
  import rv32_pkg::*;
(
  input  logic [RADDR_W-1:0] rs_addr_i,
  input  logic [XLEN-1:0]    rs_data_i,
  input  logic [RADDR_W-1:0] exmem_rd_i,
  input  logic               exmem_reg_write_i,
  input  logic [XLEN-1:0]    exmem_result_i,
  input  logic [RADDR_W-1:0] memwb_rd_i,
  input  logic               memwb_reg_write_i,
  input  logic [XLEN-1:0]    memwb_result_i,
  output logic [XLEN-1:0]    fwd_data_c_o
);

  // Pick the youngest in-flight producer of rs, else the stored register value.
  always_comb begin
    fwd_data_c_o = rs_data_i;
    if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == rs_addr_i)) begin
      fwd_data_c_o = exmem_result_i;
    end else if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == rs_addr_i)) begin
      fwd_data_c_o = memwb_result_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection and operand forwarding.
module id_ex_stage
  import rv32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  id_ex_stage_if.slave bus
);

  ex_ctrl_t        ctrl_q, ctrl_d;
  ex_data_t        data_q, data_d;
  logic            load_use_c;
  logic [XLEN-1:0] fwd_rs1_c;
  logic [XLEN-1:0] fwd_rs2_c;

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    load_use_c = 1'b0;
    if (ctrl_q.valid && ctrl_q.mem_read && (ctrl_q.rd != '0) && bus.id_valid) begin
      load_use_c = (bus.id_uses_rs1 && (bus.id_rs1_addr == ctrl_q.rd)) ||
                   (bus.id_uses_rs2 && (bus.id_rs2_addr == ctrl_q.rd));
    end
  end

  // Next-state select: flush > hold > load-use bubble > capture ID.
  always_comb begin
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (bus.ex_flush) begin
      ctrl_d = BUBBLE_CTRL;
      data_d = '0;
    end else if (bus.pipe_hold) begin
      ctrl_d = ctrl_q;
      data_d = data_q;
    end else if (load_use_c) begin
      ctrl_d = BUBBLE_CTRL;
      data_d = '0;
    end else begin
      ctrl_d.valid     = bus.id_valid;
      ctrl_d.rd        = bus.id_rd_addr;
      ctrl_d.reg_write = bus.id_reg_write;
      ctrl_d.mem_read  = bus.id_mem_read;
      ctrl_d.mem_write = bus.id_mem_write;
      ctrl_d.alu_src   = bus.id_alu_src;
      ctrl_d.alu_pc    = bus.id_alu_pc;
      ctrl_d.alucntl   = bus.id_alucntl;
      ctrl_d.funct     = bus.id_funct;
      data_d.pc        = bus.id_pc;
      data_d.rs1_addr  = bus.id_rs1_addr;
      data_d.rs2_addr  = bus.id_rs2_addr;
      data_d.rs1_data  = bus.id_rs1_data;
      data_d.rs2_data  = bus.id_rs2_data;
      data_d.imm       = bus.id_imm;
    end
  end

  // ID/EX register; reset clears every field, including ALU control.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  fwd_unit u_fwd_rs1 (
    .rs_addr_i         (data_q.rs1_addr),
    .rs_data_i         (data_q.rs1_data),
    .exmem_rd_i        (bus.exmem_rd),
    .exmem_reg_write_i (bus.exmem_reg_write),
    .exmem_result_i    (bus.exmem_result),
    .memwb_rd_i        (bus.memwb_rd),
    .memwb_reg_write_i (bus.memwb_reg_write),
    .memwb_result_i    (bus.memwb_result),
    .fwd_data_c_o      (fwd_rs1_c)
  );

  fwd_unit u_fwd_rs2 (
    .rs_addr_i         (data_q.rs2_addr),
    .rs_data_i         (data_q.rs2_data),
    .exmem_rd_i        (bus.exmem_rd),
    .exmem_reg_write_i (bus.exmem_reg_write),
    .exmem_result_i    (bus.exmem_result),
    .memwb_rd_i        (bus.memwb_rd),
    .memwb_reg_write_i (bus.memwb_reg_write),
    .memwb_result_i    (bus.memwb_result),
    .fwd_data_c_o      (fwd_rs2_c)
  );

  // EX-side outputs: operand muxes after forwarding, control straight from the register.
  assign bus.id_stall      = load_use_c;
  assign bus.ex_valid      = ctrl_q.valid;
  assign bus.ex_op1        = ctrl_q.alu_pc  ? data_q.pc  : fwd_rs1_c;
  assign bus.ex_op2        = ctrl_q.alu_src ? data_q.imm : fwd_rs2_c;
  assign bus.ex_store_data = fwd_rs2_c;
  assign bus.ex_alucntl    = ctrl_q.alucntl;
  assign bus.ex_funct      = ctrl_q.funct;
  assign bus.ex_pc         = data_q.pc;
  assign bus.ex_rd         = ctrl_q.rd;
  assign bus.ex_reg_write  = ctrl_q.reg_write;
  assign bus.ex_mem_read   = ctrl_q.mem_read;
  assign bus.ex_mem_write  = ctrl_q.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed scenarios plus randomized run against a model.
module tb_id_ex_stage;
  import rv32_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  id_ex_stage_if bus ();
  id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

  // Model of the instruction sitting in EX.
  typedef struct {
    bit          valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1a, rs2a, rd;
    bit          alu_src, alu_pc, rw, mr, mw;
    logic [3:0]  alucntl;
    logic [2:0]  funct;
  } mex_t;

  mex_t m;

  function automatic mex_t m_empty(bit bubble);
    mex_t e;
    e.valid = 0; e.pc = 0; e.rs1d = 0; e.rs2d = 0; e.imm = 0;
    e.rs1a = 0; e.rs2a = 0; e.rd = 0;
    e.alu_src = 0; e.alu_pc = 0; e.rw = 0; e.mr = 0; e.mw = 0;
    e.alucntl = bubble ? 4'b0110 : 4'b0000;
    e.funct = 0;
    return e;
  endfunction

  function automatic bit m_stall();
    if (!(m.valid && m.mr && m.rd != 0 && bus.id_valid)) return 0;
    return (bus.id_uses_rs1 && bus.id_rs1_addr == m.rd) ||
           (bus.id_uses_rs2 && bus.id_rs2_addr == m.rd);
  endfunction

  function automatic logic [31:0] m_fwd(logic [4:0] a, logic [31:0] d);
    if (bus.exmem_reg_write && bus.exmem_rd != 0 && bus.exmem_rd == a) return bus.exmem_result;
    if (bus.memwb_reg_write && bus.memwb_rd != 0 && bus.memwb_rd == a) return bus.memwb_result;
    return d;
  endfunction

  // Advance one clock, updating the model with the inputs the DUT sees.
  task automatic clock_edge();
    bit st;
    st = m_stall();
    @(posedge clk);
    if (bus.ex_flush)       m = m_empty(1);
    else if (bus.pipe_hold) m = m;
    else if (st)            m = m_empty(1);
    else begin
      m.valid = bus.id_valid; m.pc = bus.id_pc;
      m.rs1a = bus.id_rs1_addr; m.rs2a = bus.id_rs2_addr; m.rd = bus.id_rd_addr;
      m.rs1d = bus.id_rs1_data; m.rs2d = bus.id_rs2_data; m.imm = bus.id_imm;
      m.alu_src = bus.id_alu_src; m.alu_pc = bus.id_alu_pc;
      m.alucntl = bus.id_alucntl; m.funct = bus.id_funct;
      m.rw = bus.id_reg_write; m.mr = bus.id_mem_read; m.mw = bus.id_mem_write;
    end
    #2;
  endtask

  task automatic idle_inputs();
    bus.id_valid = 0; bus.id_pc = 0; bus.id_rs1_addr = 0; bus.id_rs2_addr = 0;
    bus.id_rd_addr = 0; bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0;
    bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_imm = 0;
    bus.id_alu_src = 0; bus.id_alu_pc = 0; bus.id_alucntl = 0; bus.id_funct = 0;
    bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_mem_write = 0;
    bus.pipe_hold = 0; bus.ex_flush = 0;
    bus.exmem_rd = 0; bus.exmem_reg_write = 0; bus.exmem_result = 0;
    bus.memwb_rd = 0; bus.memwb_reg_write = 0; bus.memwb_result = 0;
  endtask

  // Valid register-register instruction in ID.
  task automatic set_rr(logic [31:0] pc, logic [4:0] rs1a, logic [31:0] rs1d,
                        logic [4:0] rs2a, logic [31:0] rs2d, logic [4:0] rd,
                        logic [3:0] alucntl);
    bus.id_valid = 1; bus.id_pc = pc;
    bus.id_rs1_addr = rs1a; bus.id_rs1_data = rs1d; bus.id_uses_rs1 = 1;
    bus.id_rs2_addr = rs2a; bus.id_rs2_data = rs2d; bus.id_uses_rs2 = 1;
    bus.id_rd_addr = rd; bus.id_reg_write = 1; bus.id_mem_read = 0; bus.id_mem_write = 0;
    bus.id_alu_src = 0; bus.id_alu_pc = 0; bus.id_imm = 0;
    bus.id_alucntl = alucntl; bus.id_funct = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.id_stall !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: valid=%b stall=%b required 0 0", bus.ex_valid, bus.id_stall);
    end
    checks++;
    if ({bus.ex_op1, bus.ex_op2, bus.ex_store_data, bus.ex_pc} !== 128'h0) begin
      errors++; $display("FAIL reset_data: op1=%h op2=%h sd=%h pc=%h required 0",
                         bus.ex_op1, bus.ex_op2, bus.ex_store_data, bus.ex_pc);
    end
    checks++;
    if ({bus.ex_alucntl, bus.ex_funct, bus.ex_rd, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write} !== 15'h0) begin
      errors++; $display("FAIL reset_fields: alucntl=%b funct=%b rd=%0d rw=%b mr=%b mw=%b required 0",
                         bus.ex_alucntl, bus.ex_funct, bus.ex_rd, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write);
    end
    rst = 0;
    m = m_empty(0);
  endtask

  task automatic test_basic_add();
    idle_inputs();
    set_rr(32'h40, 5'd1, 32'd10, 5'd2, 32'd20, 5'd4, 4'b0110);
    clock_edge();
    idle_inputs();
    #1;
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.ex_op1 !== 32'd10 || bus.ex_op2 !== 32'd20 || bus.ex_alucntl !== 4'b0110) begin
      errors++; $display("FAIL basic_add: valid=%b op1=%0d op2=%0d alucntl=%b required 1 10 20 0110",
                         bus.ex_valid, bus.ex_op1, bus.ex_op2, bus.ex_alucntl);
    end
    checks++;
    if (bus.ex_pc !== 32'h40 || bus.ex_rd !== 5'd4 || bus.ex_reg_write !== 1'b1) begin
      errors++; $display("FAIL basic_fields: pc=%h rd=%0d rw=%b required 40 4 1", bus.ex_pc, bus.ex_rd, bus.ex_reg_write);
    end
  endtask

  task automatic test_forward_priority();
    idle_inputs();
    set_rr(32'h80, 5'd5, 32'h1, 5'd6, 32'h2, 5'd7, 4'b0110);
    clock_edge();
    idle_inputs();
    bus.exmem_rd = 5; bus.exmem_reg_write = 1; bus.exmem_result = 32'hAAAA_AAAA;
    bus.memwb_rd = 5; bus.memwb_reg_write = 1; bus.memwb_result = 32'h1234;
    #1;
    checks++;
    if (bus.ex_op1 !== 32'hAAAA_AAAA) begin
      errors++; $display("FAIL fwd_exmem_wins: op1=%h required aaaaaaaa", bus.ex_op1);
    end
    bus.exmem_rd = 0;
    #1;
    checks++;
    if (bus.ex_op1 !== 32'h1234) begin
      errors++; $display("FAIL fwd_exmem_x0: op1=%h required 00001234", bus.ex_op1);
    end
    bus.memwb_reg_write = 0;
    #1;
    checks++;
    if (bus.ex_op1 !== 32'h1 || bus.ex_op2 !== 32'h2) begin
      errors++; $display("FAIL fwd_none: op1=%h op2=%h required 1 2", bus.ex_op1, bus.ex_op2);
    end
  endtask

  task automatic test_load_use();
    idle_inputs();
    bus.id_valid = 1; bus.id_rs1_addr = 1; bus.id_uses_rs1 = 1; bus.id_rd_addr = 3;
    bus.id_reg_write = 1; bus.id_mem_read = 1; bus.id_alu_src = 1; bus.id_imm = 4;
    bus.id_alucntl = 4'b0110;
    clock_edge();
    set_rr(32'hC0, 5'd4, 32'd5, 5'd3, 32'd7, 5'd6, 4'b0111);
    bus.id_uses_rs1 = 1; bus.id_uses_rs2 = 1;
    #1;
    checks++;
    if (bus.id_stall !== 1'b1) begin
      errors++; $display("FAIL load_use_stall: id_stall=%b required 1", bus.id_stall);
    end
    clock_edge();
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0 || bus.ex_alucntl !== 4'b0110 || bus.ex_rd !== 5'd0) begin
      errors++; $display("FAIL load_use_bubble: valid=%b rw=%b alucntl=%b rd=%0d required 0 0 0110 0",
                         bus.ex_valid, bus.ex_reg_write, bus.ex_alucntl, bus.ex_rd);
    end
    checks++;
    if (bus.id_stall !== 1'b0) begin
      errors++; $display("FAIL load_use_release: id_stall=%b required 0", bus.id_stall);
    end
    clock_edge();
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd6 || bus.ex_op1 !== 32'd5 || bus.ex_alucntl !== 4'b0111) begin
      errors++; $display("FAIL load_use_enter: valid=%b rd=%0d op1=%0d alucntl=%b required 1 6 5 0111",
                         bus.ex_valid, bus.ex_rd, bus.ex_op1, bus.ex_alucntl);
    end
  endtask

  task automatic test_flush_hold();
    idle_inputs();
    set_rr(32'h100, 5'd1, 32'h11, 5'd2, 32'h22, 5'd9, 4'b0111);
    bus.ex_flush = 1; bus.pipe_hold = 1;
    clock_edge();
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_alucntl !== 4'b0110 || bus.ex_op1 !== 32'h0 || bus.ex_pc !== 32'h0) begin
      errors++; $display("FAIL flush_over_hold: valid=%b alucntl=%b op1=%h pc=%h required 0 0110 0 0",
                         bus.ex_valid, bus.ex_alucntl, bus.ex_op1, bus.ex_pc);
    end
    bus.ex_flush = 0; bus.pipe_hold = 0;
    clock_edge();
    bus.pipe_hold = 1;
    set_rr(32'h200, 5'd3, 32'h33, 5'd4, 32'h44, 5'd10, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      clock_edge();
      checks++;
      if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 32'h100 || bus.ex_op1 !== 32'h11 ||
          bus.ex_op2 !== 32'h22 || bus.ex_rd !== 5'd9 || bus.ex_alucntl !== 4'b0111) begin
        errors++; $display("FAIL hold_cycle%0d: valid=%b pc=%h op1=%h op2=%h rd=%0d alucntl=%b required 1 100 11 22 9 0111",
                           i, bus.ex_valid, bus.ex_pc, bus.ex_op1, bus.ex_op2, bus.ex_rd, bus.ex_alucntl);
      end
    end
    bus.pipe_hold = 0;
  endtask

  task automatic test_flush_with_stall();
    idle_inputs();
    bus.id_valid = 1; bus.id_rd_addr = 3; bus.id_reg_write = 1; bus.id_mem_read = 1;
    bus.id_alucntl = 4'b0110;
    clock_edge();
    set_rr(32'h300, 5'd3, 32'h5, 5'd0, 32'h0, 5'd8, 4'b0110);
    bus.id_uses_rs2 = 0;
    bus.ex_flush = 1;
    #1;
    checks++;
    if (bus.id_stall !== 1'b1) begin
      errors++; $display("FAIL flush_stall_req: id_stall=%b required 1", bus.id_stall);
    end
    clock_edge();
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_mem_read !== 1'b0 || bus.ex_rd !== 5'd0) begin
      errors++; $display("FAIL flush_stall_bubble: valid=%b mr=%b rd=%0d required 0 0 0",
                         bus.ex_valid, bus.ex_mem_read, bus.ex_rd);
    end
    bus.ex_flush = 0;
  endtask

  task automatic test_store_fwd();
    idle_inputs();
    bus.id_valid = 1; bus.id_pc = 32'h400;
    bus.id_rs1_addr = 2; bus.id_rs1_data = 32'h1000; bus.id_uses_rs1 = 1;
    bus.id_rs2_addr = 7; bus.id_rs2_data = 32'h0; bus.id_uses_rs2 = 1;
    bus.id_imm = 8; bus.id_alu_src = 1; bus.id_mem_write = 1; bus.id_alucntl = 4'b0110;
    clock_edge();
    idle_inputs();
    bus.memwb_rd = 7; bus.memwb_reg_write = 1; bus.memwb_result = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (bus.ex_op2 !== 32'd8 || bus.ex_store_data !== 32'hDEAD_BEEF || bus.ex_op1 !== 32'h1000 || bus.ex_mem_write !== 1'b1) begin
      errors++; $display("FAIL store_fwd: op2=%h sd=%h op1=%h mw=%b required 8 deadbeef 1000 1",
                         bus.ex_op2, bus.ex_store_data, bus.ex_op1, bus.ex_mem_write);
    end
    bus.pipe_hold = 1;
    bus.exmem_rd = 7; bus.exmem_reg_write = 1; bus.exmem_result = 32'h55;
    clock_edge();
    checks++;
    if (bus.ex_store_data !== 32'h55 || bus.ex_op2 !== 32'd8) begin
      errors++; $display("FAIL hold_fwd_live: sd=%h op2=%h required 55 8", bus.ex_store_data, bus.ex_op2);
    end
    bus.pipe_hold = 0;
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    set_rr(32'h500, 5'd1, 32'h77, 5'd2, 32'h88, 5'd5, 4'b0111);
    clock_edge();
    idle_inputs();
    #1 rst = 1;
    #1;
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_op1 !== 32'h0 || bus.ex_op2 !== 32'h0 || bus.ex_pc !== 32'h0 ||
        bus.ex_rd !== 5'd0 || bus.ex_alucntl !== 4'b0000 || bus.ex_reg_write !== 1'b0 || bus.id_stall !== 1'b0) begin
      errors++; $display("FAIL reset_mid: valid=%b op1=%h op2=%h pc=%h rd=%0d alucntl=%b rw=%b stall=%b required all 0",
                         bus.ex_valid, bus.ex_op1, bus.ex_op2, bus.ex_pc, bus.ex_rd, bus.ex_alucntl, bus.ex_reg_write, bus.id_stall);
    end
    #1 rst = 0;
    m = m_empty(0);
    set_rr(32'h600, 5'd1, 32'h99, 5'd2, 32'hAA, 5'd6, 4'b0001);
    clock_edge();
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.ex_op1 !== 32'h99 || bus.ex_pc !== 32'h600) begin
      errors++; $display("FAIL reset_first_load: valid=%b op1=%h pc=%h required 1 99 600",
                         bus.ex_valid, bus.ex_op1, bus.ex_pc);
    end
  endtask

  task automatic test_random();
    logic [31:0] e_op1, e_op2, e_sd;
    logic [127:0] act, exp_v;
    logic [15:0]  act_c, exp_c;
    bit e_st;
    for (int n = 0; n < 400; n++) begin
      bus.id_valid     = ($urandom_range(0, 7) != 0);
      bus.id_pc        = $urandom;
      bus.id_rs1_addr  = 5'($urandom_range(0, 3));
      bus.id_rs2_addr  = 5'($urandom_range(0, 3));
      bus.id_rd_addr   = 5'($urandom_range(0, 3));
      bus.id_uses_rs1  = 1'($urandom);
      bus.id_uses_rs2  = 1'($urandom);
      bus.id_rs1_data  = $urandom;
      bus.id_rs2_data  = $urandom;
      bus.id_imm       = $urandom;
      bus.id_alu_src   = 1'($urandom);
      bus.id_alu_pc    = ($urandom_range(0, 3) == 0);
      bus.id_alucntl   = 4'($urandom_range(0, 7));
      bus.id_funct     = 3'($urandom);
      bus.id_reg_write = 1'($urandom);
      bus.id_mem_read  = ($urandom_range(0, 2) == 0);
      bus.id_mem_write = ($urandom_range(0, 3) == 0);
      bus.pipe_hold    = ($urandom_range(0, 5) == 0);
      bus.ex_flush     = ($urandom_range(0, 9) == 0);
      bus.exmem_rd        = 5'($urandom_range(0, 3));
      bus.exmem_reg_write = 1'($urandom);
      bus.exmem_result    = $urandom;
      bus.memwb_rd        = 5'($urandom_range(0, 3));
      bus.memwb_reg_write = 1'($urandom);
      bus.memwb_result    = $urandom;
      #1;
      e_st  = m_stall();
      e_sd  = m_fwd(m.rs2a, m.rs2d);
      e_op1 = m.alu_pc  ? m.pc  : m_fwd(m.rs1a, m.rs1d);
      e_op2 = m.alu_src ? m.imm : e_sd;
      act   = {bus.ex_op1, bus.ex_op2, bus.ex_store_data, bus.ex_pc};
      exp_v = {e_op1, e_op2, e_sd, m.pc};
      act_c = {bus.id_stall, bus.ex_valid, bus.ex_rd, bus.ex_alucntl, bus.ex_funct,
               bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write};
      exp_c = {e_st, m.valid, m.rd, m.alucntl, m.funct, m.rw, m.mr, m.mw};
      checks++;
      if (act !== exp_v || act_c !== exp_c) begin
        errors++; $display("FAIL random_%0d: data=%h ctrl=%h required data=%h ctrl=%h", n, act, act_c, exp_v, exp_c);
      end
      clock_edge();
    end
    idle_inputs();
  endtask

  initial begin
    m = m_empty(0);
    test_reset();
    test_basic_add();
    test_forward_priority();
    test_load_use();
    test_flush_hold();
    test_flush_with_stall();
    test_store_fwd();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
